wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//  Writeback-side sequencer driving the register file write interface
//  (regwrite/write_addr/write_data and hl_write_enable_from_wb/hl_data).
//  Merges in-order pipeline writes (GPR, CP0, HI/LO via 7-bit address) with
//  out-of-order 64-bit mul/div results queued in a small FIFO. Guarantees
//  one HI/LO writer per cycle and program-order HI/LO results.
// PARAMETERS
//  HL_DEPTH   2   mul/div result FIFO entries (power of two, >=2)
//  DATA_W     32  GPR/CP0/HI/LO data width
//  ADDR_W     7   unified address: [6]=HI/LO (7'h7F HI, 7'h40 LO), [5]=CP0, else GPR
// PORTS
//  clk                      in   1       rising-edge clock
//  rst                      in   1       async, active-high reset
//  wb_valid                 in   1       pipeline WB write request this cycle
//  wb_addr                  in   7       unified destination address
//  wb_data                  in   32      write data
//  md_valid                 in   1       mul/div result offered
//  md_ready                 out  1       FIFO accepts (count < HL_DEPTH)
//  md_hl                    in   64      {hi,lo} result
//  hl_busy                  out  1       FIFO non-empty or hl write in flight (ID stalls MFHI/MFLO)
//  regwrite                 out  1       registered write enable to register file
//  write_addr               out  7       registered address
//  write_data               out  32      registered data
//  hl_write_enable_from_wb  out  1       registered HI/LO pair write enable
//  hl_data                  out  64      registered {hi,lo}
// BEHAVIOUR
//  - Reset (async): all outputs 0, FIFO count/pointers 0, md_ready=1 after release.
//  - Pipeline path: 1-cycle latency. Cycle N wb_valid -> cycle N+1 regwrite=1,
//    write_addr/write_data = sampled values. wb_valid=0 -> regwrite=0, addr/data hold.
//  - Push: md_valid && md_ready at edge N stores md_hl at tail. md_ready depends
//    only on count (no same-cycle pop credit); full -> md_ready=0.
//  - Pop: FIFO non-empty and NOT blocked -> head drives hl_data, enable=1 next cycle.
//    Blocked when wb_valid && wb_addr[6] (pipeline HI/LO write owns the cycle).
//    No bypass: min push-to-hl_write_enable latency 2 cycles.
//  - Merge (program order): wb_valid && wb_addr==7'h7F overwrites [63:32] of every
//    stored entry with wb_data; wb_addr==7'h40 overwrites [31:0]. An entry pushed
//    the same cycle is treated as older and is merged too. The pipeline write is
//    still forwarded to regwrite.
//  - Push and pop same cycle: count unchanged; pointers wrap modulo HL_DEPTH.
//  - hl_busy = (count != 0) | hl_write_enable_from_wb.
//  - Reset mid-operation drops queued results; no partial writes emitted.
// CONFIGURATION
//  WB_ZERO_GUARD_EN defined: wb_addr==7'h00 never raises regwrite (GPR $0 stays 0).
//  Undefined: $0 writes forwarded unchanged; register file holds whatever is written.
// STRUCTURE
//  Shared package regfile_pkg: ADDR_HI=7'h7F, ADDR_LO=7'h40, ADDR_CP0_BIT=5,
//  ADDR_HL_BIT=6, DATA_W, ADDR_W; reused by register file and decode.
//  Sub-module wb_hl_fifo: HL_DEPTH x 64 storage, count, pointers, per-half merge
//  write ports. Top keeps output registers, block/merge logic, zero guard.
// TESTING
//  1. wb_valid, addr 7'h05, data 32'hDEADBEEF -> next cycle regwrite=1, addr 5, data DEADBEEF.
//  2. md_valid {32'h1,32'h2}, idle pipeline -> hl_write_enable=1, hl_data=64'h1_00000002
//     two cycles later; hl_busy high from push until that cycle ends.
//  3. Fill FIFO (2 pushes), hold wb_addr=7'h40 writes -> md_ready=0, no hl write;
//     release -> entries drain in order, one per cycle.
//  4. Queue {32'hA,32'hB}, then wb_addr=7'h7F data 32'h77 -> regwrite hi=77, later
//     hl_data=64'h00000077_0000000B.
//  5. Assert rst with 2 entries queued -> all outputs 0 immediately, no hl write after release.
//  6. WB_ZERO_GUARD_EN: wb_addr 7'h00 data 32'h1234 -> regwrite stays 0; without macro -> 1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file addressing constants and destination decode helper,
// reused by the register file, decode and writeback arbitration.
package regfile_pkg;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 7;
  localparam int ADDR_CP0_BIT = 5;
  localparam int ADDR_HL_BIT  = 6;

  localparam logic [ADDR_W-1:0] ADDR_HI = 7'h7F;
  localparam logic [ADDR_W-1:0] ADDR_LO = 7'h40;

  typedef enum logic [1:0] {
    DEST_GPR,
    DEST_CP0,
    DEST_HL
  } dest_e;

  function automatic dest_e dest_of(input logic [ADDR_W-1:0] addr);
    if (addr[ADDR_HL_BIT])  return DEST_HL;
    if (addr[ADDR_CP0_BIT]) return DEST_CP0;
    return DEST_GPR;
  endfunction

endpackage

// File: rtl/wb_hl_fifo.sv
// Small FIFO of {hi,lo} mul/div results with per-half merge ports so later
// pipeline HI/LO writes overwrite all queued (older) results.
module wb_hl_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [2*W-1:0]  push_data,
  input  logic            pop,
  input  logic            merge_hi,
  input  logic            merge_lo,
  input  logic [W-1:0]    merge_data,
  output logic [2*W-1:0]  head,
  output logic [CW-1:0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [2*W-1:0] mem_q [DEPTH];
  logic [2*W-1:0] mem_d [DEPTH];
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  // The entry being pushed this cycle is older than the pipeline write, so
  // the merge is applied after the push data lands.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (push && tail_q == PW'(i)) mem_d[i] = push_data;
      if (merge_hi) mem_d[i][2*W-1:W] = merge_data;
      if (merge_lo) mem_d[i][W-1:0]   = merge_data;
    end
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Writeback-side register file write sequencer merging pipeline writes with
// queued mul/div HI/LO results. Optional macro: WB_ZERO_GUARD_EN.
module wb_write_arbiter #(
  parameter int HL_DEPTH = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                md_valid,
  output logic                md_ready,
  input  logic [2*DATA_W-1:0] md_hl,
  output logic                hl_busy,
  output logic                regwrite,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [DATA_W-1:0]   write_data,
  output logic                hl_write_enable_from_wb,
  output logic [2*DATA_W-1:0] hl_data
);
  import regfile_pkg::*;

  localparam int CW = $clog2(HL_DEPTH) + 1;

  logic [CW-1:0]       count;
  logic [2*DATA_W-1:0] head;
  logic                hl_block, merge_hi, merge_lo, push, pop, wb_en;

  logic                regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]   write_addr_q, write_addr_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic                hl_we_q, hl_we_d;
  logic [2*DATA_W-1:0] hl_data_q, hl_data_d;

  assign md_ready = !rst && (count < CW'(HL_DEPTH));

  always_comb begin
    hl_block = wb_valid && (dest_of(wb_addr) == DEST_HL);
    merge_hi = wb_valid && (wb_addr == ADDR_HI);
    merge_lo = wb_valid && (wb_addr == ADDR_LO);
    push     = md_valid && md_ready;
    pop      = (count != '0) && !hl_block;
`ifdef WB_ZERO_GUARD_EN
    wb_en    = wb_valid && (wb_addr != '0);
`else
    wb_en    = wb_valid;
`endif
    regwrite_d   = wb_en;
    write_addr_d = wb_en ? wb_addr : write_addr_q;
    write_data_d = wb_en ? wb_data : write_data_q;
    hl_we_d      = pop;
    hl_data_d    = pop ? head : hl_data_q;
  end

  wb_hl_fifo #(
    .DEPTH (HL_DEPTH),
    .W     (DATA_W),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (md_hl),
    .pop        (pop),
    .merge_hi   (merge_hi),
    .merge_lo   (merge_lo),
    .merge_data (wb_data),
    .head       (head),
    .count      (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      hl_we_q      <= 1'b0;
      hl_data_q    <= '0;
    end else begin
      regwrite_q   <= regwrite_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      hl_we_q      <= hl_we_d;
      hl_data_q    <= hl_data_d;
    end
  end

  assign regwrite                = regwrite_q;
  assign write_addr              = write_addr_q;
  assign write_data              = write_data_q;
  assign hl_write_enable_from_wb = hl_we_q;
  assign hl_data                 = hl_data_q;
  assign hl_busy                 = (count != '0) | hl_we_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: pipeline path, HI/LO queue, merge,
// blocking, reset and the optional $0 guard.
module tb_wb_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [6:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [63:0] md_hl;
  logic        hl_busy;
  logic        regwrite;
  logic [6:0]  write_addr;
  logic [31:0] write_data;
  logic        hl_we;
  logic [63:0] hl_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(.HL_DEPTH(2), .DATA_W(32), .ADDR_W(7)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .wb_valid                (wb_valid),
    .wb_addr                 (wb_addr),
    .wb_data                 (wb_data),
    .md_valid                (md_valid),
    .md_ready                (md_ready),
    .md_hl                   (md_hl),
    .hl_busy                 (hl_busy),
    .regwrite                (regwrite),
    .write_addr              (write_addr),
    .write_data              (write_data),
    .hl_write_enable_from_wb (hl_we),
    .hl_data                 (hl_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    md_valid = 1'b0; md_hl = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    checks++;
    if ({regwrite, write_addr, write_data, hl_we, hl_data, hl_busy, md_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: regwrite=%b addr=%h data=%h hl_we=%b hl_data=%h busy=%b ready=%b, required all 0",
               regwrite, write_addr, write_data, hl_we, hl_data, hl_busy, md_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (md_ready !== 1'b1 || hl_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b, required ready=1 busy=0", md_ready, hl_busy);
    end
    tick();
  endtask

  task automatic test_pipeline();
    wb_valid = 1'b1; wb_addr = 7'h05; wb_data = 32'hDEADBEEF;
    tick();
    checks++;
    if (regwrite !== 1'b1 || write_addr !== 7'h05 || write_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL pipe_write: regwrite=%b addr=%h data=%h, required 1 05 deadbeef", regwrite, write_addr, write_data);
    end
    wb_valid = 1'b0; wb_addr = 7'h11; wb_data = 32'h12345678;
    tick();
    checks++;
    if (regwrite !== 1'b0 || write_addr !== 7'h05 || write_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL pipe_hold: regwrite=%b addr=%h data=%h, required 0 05 deadbeef", regwrite, write_addr, write_data);
    end
    idle_inputs();
  endtask

  task automatic test_md_latency();
    md_valid = 1'b1; md_hl = {32'h1, 32'h2};
    #1;
    checks++;
    if (md_ready !== 1'b1) begin
      errors++;
      $display("FAIL md_ready_empty: got %b, required 1", md_ready);
    end
    tick();
    md_valid = 1'b0;
    checks++;
    if (hl_we !== 1'b0 || hl_busy !== 1'b1) begin
      errors++;
      $display("FAIL md_after_push: hl_we=%b busy=%b, required 0 1", hl_we, hl_busy);
    end
    tick();
    checks++;
    if (hl_we !== 1'b1 || hl_data !== 64'h00000001_00000002 || hl_busy !== 1'b1) begin
      errors++;
      $display("FAIL md_write: hl_we=%b data=%h busy=%b, required 1 0000000100000002 1", hl_we, hl_data, hl_busy);
    end
    tick();
    checks++;
    if (hl_we !== 1'b0 || hl_busy !== 1'b0) begin
      errors++;
      $display("FAIL md_done: hl_we=%b busy=%b, required 0 0", hl_we, hl_busy);
    end
  endtask

  task automatic test_block_and_drain();
    wb_valid = 1'b1; wb_addr = 7'h40; wb_data = 32'h55;
    md_valid = 1'b1; md_hl = {32'h11, 32'h1};
    tick();
    md_hl = {32'h22, 32'h2}; wb_data = 32'h66;
    checks++;
    if (md_ready !== 1'b1 || hl_we !== 1'b0) begin
      errors++;
      $display("FAIL fill_one: ready=%b hl_we=%b, required 1 0", md_ready, hl_we);
    end
    tick();
    md_hl = {32'h33, 32'h3}; wb_data = 32'h77;
    checks++;
    if (md_ready !== 1'b0 || hl_we !== 1'b0 || write_data !== 32'h66) begin
      errors++;
      $display("FAIL fill_full: ready=%b hl_we=%b wdata=%h, required 0 0 66", md_ready, hl_we, write_data);
    end
    tick();
    checks++;
    if (md_ready !== 1'b0 || hl_we !== 1'b0 || regwrite !== 1'b1 || write_addr !== 7'h40 || write_data !== 32'h77) begin
      errors++;
      $display("FAIL blocked: ready=%b hl_we=%b rw=%b addr=%h data=%h, required 0 0 1 40 77",
               md_ready, hl_we, regwrite, write_addr, write_data);
    end
    idle_inputs();
    tick();
    checks++;
    if (hl_we !== 1'b1 || hl_data !== 64'h00000011_00000077 || md_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain0: hl_we=%b data=%h ready=%b, required 1 0000001100000077 1", hl_we, hl_data, md_ready);
    end
    tick();
    checks++;
    if (hl_we !== 1'b1 || hl_data !== 64'h00000022_00000077) begin
      errors++;
      $display("FAIL drain1: hl_we=%b data=%h, required 1 0000002200000077", hl_we, hl_data);
    end
    tick();
    checks++;
    if (hl_we !== 1'b0 || hl_busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: hl_we=%b busy=%b, required 0 0", hl_we, hl_busy);
    end
  endtask

  task automatic test_merge_hi();
    md_valid = 1'b1; md_hl = {32'hA, 32'hB};
    tick();
    md_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 7'h7F; wb_data = 32'h77;
    tick();
    wb_valid = 1'b0;
    checks++;
    if (regwrite !== 1'b1 || write_addr !== 7'h7F || write_data !== 32'h77 || hl_we !== 1'b0) begin
      errors++;
      $display("FAIL merge_fwd: rw=%b addr=%h data=%h hl_we=%b, required 1 7f 77 0", regwrite, write_addr, write_data, hl_we);
    end
    tick();
    checks++;
    if (hl_we !== 1'b1 || hl_data !== 64'h00000077_0000000B) begin
      errors++;
      $display("FAIL merge_hl: hl_we=%b data=%h, required 1 000000770000000b", hl_we, hl_data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    wb_valid = 1'b1; wb_addr = 7'h41; wb_data = 32'h9;
    md_valid = 1'b1; md_hl = {32'hC, 32'hD};
    tick();
    md_hl = {32'hE, 32'hF};
    tick();
    checks++;
    if (hl_busy !== 1'b1 || md_ready !== 1'b0 || regwrite !== 1'b1) begin
      errors++;
      $display("FAIL queued_two: busy=%b ready=%b rw=%b, required 1 0 1", hl_busy, md_ready, regwrite);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({regwrite, write_addr, write_data, hl_we, hl_data, hl_busy, md_ready} !== '0) begin
      errors++;
      $display("FAIL reset_mid: rw=%b addr=%h data=%h hl_we=%b hl_data=%h busy=%b ready=%b, required all 0",
               regwrite, write_addr, write_data, hl_we, hl_data, hl_busy, md_ready);
    end
    idle_inputs();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (hl_we !== 1'b0 || hl_busy !== 1'b0 || md_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_%0d: hl_we=%b busy=%b ready=%b, required 0 0 1", i, hl_we, hl_busy, md_ready);
      end
    end
  endtask

  task automatic test_zero_guard();
    logic exp_rw;
`ifdef WB_ZERO_GUARD_EN
    exp_rw = 1'b0;
`else
    exp_rw = 1'b1;
`endif
    wb_valid = 1'b1; wb_addr = 7'h00; wb_data = 32'h1234;
    tick();
    idle_inputs();
    checks++;
    if (regwrite !== exp_rw) begin
      errors++;
      $display("FAIL zero_guard: regwrite=%b, required %b", regwrite, exp_rw);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_md_latency();
    test_block_and_drain();
    test_merge_hi();
    test_reset_mid();
    test_zero_guard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
